// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline stage registers:
// default widths, the canonical NOP, skid-buffer states and the IF/ID payload.
package riscv_pipe_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ILEN_DEFAULT = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [ILEN_DEFAULT-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/pipe_data_reg.sv
// Width-parameterised enable register with asynchronous active-low reset,
// used for the payload slots of pipeline skid buffers.
module pipe_data_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID boundary register with a 2-entry skid buffer and registered in_ready.
// Optional macro IF_ID_STALL_CNT_EN adds a saturating decode-stall counter.
//
// Handshake: a transfer happens on a side in any cycle where valid && ready
// are both high at the rising edge; valid never waits on ready, and flush
// overrides both sides' transfers in the cycle it is asserted.
module if_id_skid_reg
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int ILEN = ILEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [ILEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
`ifdef IF_ID_STALL_CNT_EN
  output logic [31:0]     stall_cnt,
`endif
  output skid_state_e     state_dbg
);

  localparam int PW = XLEN + ILEN;

  skid_state_e   state_q, state_d;
  logic          in_ready_q;
  logic          main_en, skid_en;
  logic [PW-1:0] in_payload, main_d, main_q, skid_q;

  assign in_payload = {in_pc, in_instr};

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_payload;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_valid) begin
            main_en = 1'b1;
            state_d = FULL;
          end
        end
        FULL: begin
          if (in_valid && out_ready) begin
            main_en = 1'b1;
          end else if (in_valid) begin
            skid_en = 1'b1;
            state_d = SKID;
          end else if (out_ready) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (out_ready) begin
            main_en = 1'b1;
            main_d  = skid_q;
            state_d = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != SKID);
    end
  end

  pipe_data_reg #(.W(PW)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_data_reg #(.W(PW)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (in_payload),
    .q     (skid_q)
  );

  // Stale payload is masked so decode only ever sees a NOP bubble when idle.
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_pc    = out_valid ? main_q[PW-1:ILEN] : '0;
  assign out_instr = out_valid ? main_q[ILEN-1:0] : ILEN'(NOP_INSTR);
  assign state_dbg = state_q;

`ifdef IF_ID_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed plus randomized bench for if_id_skid_reg, checked against a
// queue-based model of a 2-deep FIFO with flush.
module tb_if_id_skid_reg;
  import riscv_pipe_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  skid_state_e state_dbg;
`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
  int unsigned model_stall;
`endif

  int checks;
  int errors;
  logic [63:0] exp_q[$];

  if_id_skid_reg #(.XLEN(32), .ILEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
`ifdef IF_ID_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic        ev;
    logic [31:0] epc, einstr;
    ev     = (exp_q.size() != 0);
    epc    = ev ? exp_q[0][63:32] : 32'h0;
    einstr = ev ? exp_q[0][31:0] : 32'h0000_0013;
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_pc", 64'(out_pc), 64'(epc));
    chk("out_instr", 64'(out_instr), 64'(einstr));
    chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
`ifdef IF_ID_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(model_stall));
`endif
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, check #1 later.
  task automatic step(input logic f, input logic iv, input logic ordy,
                      input logic [31:0] pc, input logic [31:0] instr);
    bit can_accept;
    can_accept = (exp_q.size() < 2);
    flush      = f;
    in_valid   = iv;
    out_ready  = ordy;
    in_pc      = pc;
    in_instr   = instr;
`ifdef IF_ID_STALL_CNT_EN
    if (exp_q.size() != 0 && !ordy && model_stall != 32'hFFFF_FFFF) model_stall++;
`endif
    @(posedge clk);
    if (f) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
      if (iv && can_accept) exp_q.push_back({pc, instr});
    end
    #1;
    check_model();
  endtask

  task automatic apply_reset();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_instr = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
`ifdef IF_ID_STALL_CNT_EN
    model_stall = 0;
`endif
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_out_instr", 64'(out_instr), 64'h13);
    chk("reset_out_pc", 64'(out_pc), 64'h0);
    chk("reset_in_ready", 64'(in_ready), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc_ctr;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    apply_reset();

    // idle after reset
    repeat (3) step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // streaming
    step(1'b0, 1'b1, 1'b1, 32'h0, 32'h0010_0093);
    step(1'b0, 1'b1, 1'b1, 32'h4, 32'h0020_0113);
    step(1'b0, 1'b1, 1'b1, 32'h8, 32'h0030_0193);
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // back-pressure into SKID, then drain in order
    step(1'b0, 1'b1, 1'b1, 32'h100, 32'h1111_1111);
    step(1'b0, 1'b1, 1'b0, 32'h104, 32'h2222_2222);
    chk("bp_state", 64'(state_dbg), 64'(SKID));
    step(1'b0, 1'b1, 1'b0, 32'h108, 32'h3333_3333);
    chk("bp_hold_pc", 64'(out_pc), 64'h100);
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // flush in SKID with a simultaneous input
    step(1'b0, 1'b1, 1'b0, 32'h200, 32'hAAAA_0001);
    step(1'b0, 1'b1, 1'b0, 32'h204, 32'hAAAA_0002);
    step(1'b1, 1'b1, 1'b1, 32'h208, 32'hAAAA_0003);
    chk("flush_out_valid", 64'(out_valid), 64'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

`ifdef IF_ID_STALL_CNT_EN
    apply_reset();
    step(1'b0, 1'b1, 1'b0, 32'h300, 32'h0000_0013);
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("stall_cnt_five", 64'(stall_cnt), 64'd5);
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("stall_cnt_after_flush", 64'(stall_cnt), 64'd5);
`endif

    // async reset asserted mid-SKID, between edges
    step(1'b0, 1'b1, 1'b0, 32'h400, 32'hBBBB_0001);
    step(1'b0, 1'b1, 1'b0, 32'h404, 32'hBBBB_0002);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'h0);
    chk("async_out_instr", 64'(out_instr), 64'h13);
    chk("async_out_pc", 64'(out_pc), 64'h0);
    chk("async_in_ready", 64'(in_ready), 64'h1);
    apply_reset();

    // randomized traffic
    pc_ctr = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      logic f, iv, ordy;
      f    = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      step(f, iv, ordy, pc_ctr, $urandom);
      if (iv) pc_ctr = pc_ctr + 32'd4;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
